uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-format defaults and receiver state encoding
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEF = 16;
    localparam int UART_DATA_BITS_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-flop synchronizer with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1-style serial receiver with valid/ready byte output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = UART_DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic rxd_s;
    logic rxd_s_d;

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d;
    logic                 ferr_d;
    logic                 ovr_d;

    // Idle-high line, so the synchronizer resets to 1 to avoid a fake start edge.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rxd),
        .q       (rxd_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rxd_s_d <= 1'b1;
        else          rxd_s_d <= rxd_s;
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
            overrun   <= ovr_d;
        end
    end

    // Frame sequencing: mid-bit sampling and holding-register update at the stop sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = rx_data;
        valid_d = rx_valid && !rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Requiring a high-to-low transition keeps a held-low break from retriggering.
                if (rxd_s_d && !rxd_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rxd_s) begin
                        ferr_d = 1'b1;
                    end else if (rx_valid && !rx_ready) begin
                        ovr_d = 1'b1;
                    end else begin
                        // Also covers a transfer in this same cycle: valid stays high with new data.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with frame-level reference timing
module tb_uart_rx;

    localparam int C   = 16;
    localparam int DB  = 8;
    localparam int FR  = (DB + 2) * C;
    localparam int LAT = 2 + C / 2 + (DB + 1) * C;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;

    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t data_q[$];
    int   ferr_q[$];
    int   ovr_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DB-1:0] d, input logic stop);
        rxd = 1'b0;
        repeat (C) tick();
        for (int k = 0; k < DB; k++) begin
            rxd = d[k];
            repeat (C) tick();
        end
        rxd = stop;
        repeat (C) tick();
    endtask

    task automatic send_exp(input logic [DB-1:0] d);
        data_q.push_back('{data: int'(d), cyc: cyc + 1 + LAT});
        send(d, 1'b1);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) begin
                if (data_q.size() == 0) begin
                    chk("unexpected_rx", int'(rx_data), -1);
                end else begin
                    exp_t e;
                    e = data_q.pop_front();
                    chk("rx_data", int'(rx_data), e.data);
                    if (e.cyc >= 0) chk("rx_cycle", cyc, e.cyc);
                end
            end
            if (frame_err) begin
                if (ferr_q.size() == 0) chk("unexpected_frame_err", cyc, -1);
                else chk("frame_err_cycle", cyc, ferr_q.pop_front());
            end
            if (overrun) begin
                if (ovr_q.size() == 0) chk("unexpected_overrun", cyc, -1);
                else chk("overrun_cycle", cyc, ovr_q.pop_front());
            end
        end
    end

    initial begin
        int e0;
        repeat (3) tick();
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_ovr", int'(overrun), 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // single byte, ready held high
        send_exp(8'hA5);
        repeat (4) tick();

        // back-to-back frames
        send_exp(8'h00);
        send_exp(8'hFF);
        send_exp(8'h3C);
        repeat (4) tick();

        // short low glitch, then a real frame
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (20) tick();
        send_exp(8'h5A);
        repeat (4) tick();

        // bad stop bit followed by a long break
        ferr_q.push_back(cyc + 1 + LAT);
        send(8'h81, 1'b0);
        repeat (400) tick();
        rxd = 1'b1;
        repeat (20) tick();
        send_exp(8'h81);
        repeat (4) tick();

        // overrun with consumer stalled
        rx_ready = 1'b0;
        e0 = cyc + 1;
        data_q.push_back('{data: 'h11, cyc: -1});
        ovr_q.push_back(e0 + FR + LAT);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        repeat (4) tick();
        chk("hold_valid", int'(rx_valid), 1);
        chk("hold_data", int'(rx_data), 'h11);
        rx_ready = 1'b1;
        repeat (4) tick();

        // consumer accepts exactly on the second stop-sample cycle
        rx_ready = 1'b0;
        e0 = cyc + 1;
        data_q.push_back('{data: 'h11, cyc: e0 + FR + LAT - 1});
        data_q.push_back('{data: 'h22, cyc: e0 + FR + LAT});
        fork
            begin
                send(8'h11, 1'b1);
                send(8'h22, 1'b1);
            end
            begin
                while (cyc != e0 + FR + LAT - 1) tick();
                rx_ready = 1'b1;
            end
        join
        repeat (4) tick();

        // reset in the middle of data bit 4 wipes a held byte and the partial frame
        rx_ready = 1'b0;
        send(8'h44, 1'b1);
        repeat (4) tick();
        chk("pre_reset_valid", int'(rx_valid), 1);
        fork
            send(8'hF0, 1'b1);
            begin
                repeat (2 + C / 2 + 5 * C) tick();
                reset_n = 1'b0;
                repeat (3) tick();
                chk("mid_reset_valid", int'(rx_valid), 0);
                chk("mid_reset_data", int'(rx_data), 0);
                chk("mid_reset_ferr", int'(frame_err), 0);
                chk("mid_reset_ovr", int'(overrun), 0);
                reset_n = 1'b1;
            end
        join
        rx_ready = 1'b1;
        repeat (5) tick();
        send_exp(8'h7E);

        // random bytes with random idle gaps
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 30)) tick();
            send_exp(DB'($urandom_range(0, 255)));
        end

        repeat (10) tick();
        chk("rx_pending", data_q.size(), 0);
        chk("ferr_pending", ferr_q.size(), 0);
        chk("ovr_pending", ovr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
